// File: rtl/asrm_ram_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency RAM.
// Each access is latched in IDLE, held stable through BUSY, and acknowledged in DONE.
module asrm_ram_arbiter #(
    parameter int wordsize    = 16,
    parameter int ram_latency = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_req,
    input  logic                b_req,
    input  logic [wordsize-1:0] a_addr,
    input  logic [wordsize-1:0] b_addr,
    input  logic [wordsize-1:0] a_wdata,
    input  logic [wordsize-1:0] b_wdata,
    input  logic                a_we,
    input  logic                b_we,
    output logic                a_ack,
    output logic                b_ack,
    output logic [wordsize-1:0] a_rdata,
    output logic [wordsize-1:0] b_rdata,
    output logic [wordsize-1:0] ram_addr,
    output logic [wordsize-1:0] ram_data_out,
    output logic                ram_write_en,
    input  logic [wordsize-1:0] ram_data_in,
    output logic                busy,
    output logic                grant,
    output logic [1:0]          dbg_state
);

    // Handshake: a request is taken when req is high in an IDLE cycle; the
    // access then runs to completion and ack pulses for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(ram_latency);

    state_t              state, state_next;
    logic [3:0]          count;
    logic [wordsize-1:0] lat_addr, lat_wdata;
    logic                lat_we;
    logic                last_b;
    logic                pick_b, start, finish;

    assign dbg_state = state;

    always_comb begin
        state_next   = state;
        pick_b       = 1'b0;
        start        = 1'b0;
        finish       = 1'b0;
        busy         = 1'b0;
        ram_addr     = '0;
        ram_data_out = '0;
        ram_write_en = 1'b0;
        a_ack        = 1'b0;
        b_ack        = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    start      = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    pick_b     = b_req && (!a_req || !last_b);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy         = 1'b1;
                ram_addr     = lat_addr;
                ram_data_out = lat_wdata;
                ram_write_en = lat_we && (count == LAT);
                if (count == 4'd1) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                a_ack      = !grant;
                b_ack      = grant;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            grant     <= 1'b0;
            last_b    <= 1'b1;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                count     <= LAT;
                grant     <= pick_b;
                last_b    <= pick_b;
                lat_addr  <= pick_b ? b_addr  : a_addr;
                lat_wdata <= pick_b ? b_wdata : a_wdata;
                lat_we    <= pick_b ? b_we    : a_we;
            end else if (state == BUSY) begin
                count <= count - 4'd1;
            end
            if (finish && !lat_we) begin
                if (grant) b_rdata <= ram_data_in;
                else       a_rdata <= ram_data_in;
            end
        end
    end

endmodule

// File: doc/asrm_ram_arbiter.md
ASRM_RAM_ARBITER -- requirements
Module: asrm_ram_arbiter

Interface
REQ-001 SHALL have parameter wordsize, default 16, width of address and data buses.
REQ-002 SHALL have parameter ram_latency, default 2, cycles from RAM address presentation to valid RAM read data (legal range 1..15).
REQ-003 SHALL have clk  input  1  clock, all state updates on posedge.
REQ-004 SHALL have reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have a_req, b_req  input  1  access request from port A (CPU address unit) / port B (secondary master).
REQ-006 SHALL have a_addr, b_addr  input  wordsize  request address.
REQ-007 SHALL have a_wdata, b_wdata  input  wordsize  write data.
REQ-008 SHALL have a_we, b_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have a_ack, b_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have a_rdata, b_rdata  output  wordsize  read data returned to the port.
REQ-011 SHALL have ram_addr  output  wordsize, ram_data_out  output  wordsize, ram_write_en  output  1  RAM drive signals.
REQ-012 SHALL have ram_data_in  input  wordsize  RAM read data.
REQ-013 SHALL have busy  output  1  high in BUSY and DONE; grant  output  1  port owning the current access (0 = A, 1 = B).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: if a_req or b_req is high, SHALL latch the winner's addr/wdata/we into internal registers, set grant, load the counter with ram_latency, go to BUSY; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: on simultaneous requests the port not granted last wins; a single requester always wins.
REQ-017 BUSY: ram_addr and ram_data_out SHALL be driven from the latched registers, independent of current port inputs.
REQ-018 ram_write_en SHALL be high only during the first BUSY cycle of a write access, never for reads.
REQ-019 Counter SHALL decrement each BUSY cycle; on the cycle it reaches 1, ram_data_in SHALL be registered into the granted port's rdata (reads only) and FSM SHALL go to DONE.
REQ-020 DONE: the granted port's ack SHALL be high for exactly this one cycle; FSM SHALL return to IDLE unconditionally.
REQ-021 Total latency: request sampled in IDLE at cycle T -> ack at cycle T+ram_latency+1; at most one access every ram_latency+2 cycles.
REQ-022 a_rdata/b_rdata SHALL hold their value until the next read completion on the same port; writes SHALL NOT modify rdata.
REQ-023 A request deasserted mid-access SHALL NOT abort it; the access completes and ack is still issued.
REQ-024 A request still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-025 A requester SHALL be served within two arbitration rounds while it holds req high (no starvation).
REQ-026 Outside BUSY, ram_addr and ram_data_out SHALL be 0 and ram_write_en SHALL be 0.
REQ-027 a_ack and b_ack SHALL never be high in the same cycle.

Reset
REQ-028 With reset low at a posedge, FSM SHALL go to IDLE, counter 0, grant 0, last-granted pointer set so port A wins the first tie.
REQ-029 During and after reset all outputs SHALL be 0: acks, rdata, ram_addr, ram_data_out, ram_write_en, busy.
REQ-030 Reset asserted mid-access SHALL abandon the access with no ack and no further RAM write.

Verification
REQ-031 Port A read, addr 0x0010, RAM returns 0xBEEF, ram_latency 2 -> a_ack at T+3, a_rdata = 0xBEEF, ram_write_en never high.
REQ-032 Port B write addr 0x0020 data 0x1234 -> ram_write_en high one cycle with ram_addr 0x0020, ram_data_out 0x1234; b_ack at T+3; b_rdata unchanged.
REQ-033 a_req and b_req held high from reset release -> acks alternate A, B, A, B, each ram_latency+2 cycles apart.
REQ-034 a_req pulsed one cycle, a_addr changed during BUSY -> ram_addr keeps latched value, a_ack still issued.
REQ-035 Reset driven low during BUSY of a write -> no ack, outputs 0 next cycle, FSM IDLE.
REQ-036 ram_latency 1 and 4 builds -> ack at T+2 and T+5 respectively with correct read data.
